fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default defs::RESET_VECTOR (32'd16): PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 fetch_addr  output  32  instruction address to the instruction memory; equals pc, combinational.
REQ-005 fetch_inst  input  32  instruction word returned combinationally by memory for fetch_addr, same cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; load redirect_pc, flush IF/ID.
REQ-007 redirect_pc  input  32  redirect target, byte address.
REQ-008 out_valid  output  1  IF/ID register holds a valid instruction for decode.
REQ-009 out_ready  input  1  decode accepts IF/ID contents this cycle.
REQ-010 out_inst  output  32  registered instruction word.
REQ-011 out_pc  output  32  registered address of out_inst.
REQ-012 fault  output  1  sticky fetch fault: misaligned or out-of-range PC.

Function
REQ-013 FSM states: RUN, STALL, HALT; encoding fetch_state_t in defs.
REQ-014 RUN, no redirect, (out_valid=0 or out_ready=1): out_inst<=fetch_inst, out_pc<=pc, out_valid<=1, pc<=pc+4; stay RUN.
REQ-015 RUN, no redirect, out_valid=1, out_ready=0: hold pc and IF/ID; next state STALL.
REQ-016 STALL: hold pc and IF/ID while out_ready=0; when out_ready=1, perform the REQ-014 load that same edge and return to RUN.
REQ-017 redirect_valid=1 in RUN or STALL: pc<=redirect_pc, out_valid<=0 (flush, even if out_ready=0); next state RUN; redirect has priority over stall and over a normal load.
REQ-018 Redirect latency: first instruction from redirect_pc appears on out_* exactly 2 edges after the edge sampling redirect_valid, absent stall.
REQ-019 Throughput: one instruction per cycle when out_ready held 1; out_valid never deasserts without a flush, fault or reset.
REQ-020 pc+4 wraps modulo 2^32; no carry out.
REQ-021 Fault: pc[1:0]!=0 or pc>MEM_SIZE in RUN, or redirect_pc[1:0]!=0 / redirect_pc>MEM_SIZE on a redirect -> fault<=1, out_valid<=0, state HALT; offending instruction never reaches out_*.
REQ-022 HALT: pc, out_* frozen, out_valid=0, fault=1; redirect_valid and out_ready ignored; exit only by reset.
REQ-023 out_inst/out_pc stable while out_valid=1 and out_ready=0.

Reset
REQ-024 rst_n=0 at an edge: pc<=RESET_VECTOR, out_valid<=0, out_inst<=defs::INST_NOP, out_pc<=0, fault<=0, state RUN; overrides all other inputs, including mid-stall or in HALT.
REQ-025 First valid output (inst at RESET_VECTOR) appears one edge after the first edge with rst_n=1.

Structure
REQ-026 defs package holds RESET_VECTOR, INST_NOP (32'h0000_0013), fetch_state_t, and the existing MEM_SIZE; no local copies.
REQ-027 One sub-module natural: if_id_reg (valid/ready-holding pipeline register with flush); PC and FSM stay in fetch_ctrl.

Verification
REQ-028 Reset, memory words at 16/20/24, out_ready=1 -> out_pc 16,20,24 on consecutive cycles, out_valid=1 from the second cycle after reset release.
REQ-029 out_ready=0 for 3 cycles holding out_pc=20 -> out_pc/out_inst unchanged, fetch_addr stays 24; release -> out_pc=24 next edge.
REQ-030 redirect_valid=1, redirect_pc=16 during stall at out_pc=24 -> out_valid=0 next edge, out_pc=16 the edge after.
REQ-031 redirect_pc=18 -> fault=1, out_valid=0 next edge; further redirects/ready toggles ignored until rst_n=0.
REQ-032 Sequential run past MEM_SIZE -> fault at first pc>MEM_SIZE; last valid out_pc is the final in-range word.
REQ-033 rst_n=0 asserted mid-stall and in HALT -> next edge pc=16, out_valid=0, fault=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// defs: shared constants and state encoding for the instruction fetch stage.
package defs;
  localparam logic [31:0] RESET_VECTOR = 32'd16;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] MEM_SIZE = 32'd256;
  typedef enum logic [1:0] {RUN, STALL, HALT} fetch_state_t;
  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > MEM_SIZE);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// if_id_reg: IF/ID pipeline register holding its contents until loaded or flushed.
module if_id_reg
  import defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst <= INST_NOP;
      pc <= 32'd0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst <= in_inst;
      pc <= in_pc;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, stall/redirect handling and sticky fault halt for instruction fetch.
module fetch_ctrl
  import defs::*;
#(
  parameter logic [31:0] RESET_VECTOR = defs::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n;
  logic fault_n, load, flush;

  assign fetch_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_VECTOR;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fault <= fault_n;
    end
  end

  // STALL is only entered from RUN after pc passed its check, so the pc check applies to RUN only
  always_comb begin
    state_n = state;
    pc_n = pc;
    fault_n = fault;
    load = 1'b0;
    flush = 1'b0;
    if (state != HALT) begin
      if (redirect_valid) begin
        flush = 1'b1;
        if (bad_addr(redirect_pc)) begin
          fault_n = 1'b1;
          state_n = HALT;
        end else begin
          pc_n = redirect_pc;
          state_n = RUN;
        end
      end else if (state == RUN && bad_addr(pc)) begin
        flush = 1'b1;
        fault_n = 1'b1;
        state_n = HALT;
      end else if (!out_valid || out_ready) begin
        load = 1'b1;
        pc_n = pc + 32'd4;
        state_n = RUN;
      end else begin
        state_n = STALL;
      end
    end
  end

  if_id_reg u_if_id (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .flush(flush),
    .in_inst(fetch_inst),
    .in_pc(pc),
    .valid(out_valid),
    .inst(out_inst),
    .pc(out_pc)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level fetch model.
module tb_fetch_ctrl;
  import defs::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] fetch_addr, fetch_inst, redirect_pc = 32'd0, out_inst, out_pc;
  logic redirect_valid = 1'b0, out_valid, out_ready = 1'b0, fault;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_inst, m_opc;
  logic m_valid, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a > MEM_SIZE);
  endfunction

  assign fetch_inst = mem_word(fetch_addr);

  fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_addr(fetch_addr),
    .fetch_inst(fetch_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the model by the same edge, compare all outputs
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst_n = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    @(posedge clk);
    if (!r) begin
      m_pc = RESET_VECTOR; m_valid = 0; m_inst = INST_NOP; m_opc = 0; m_fault = 0;
    end else if (!m_fault) begin
      if (rv) begin
        m_valid = 0;
        if (illegal(rpc)) m_fault = 1;
        else m_pc = rpc;
      end else if (illegal(m_pc)) begin
        m_valid = 0; m_fault = 1;
      end else if (!m_valid || rdy) begin
        m_inst = mem_word(m_pc); m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end
    end
    #1;
    check("fetch_addr", fetch_addr, m_pc);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("fault", {31'd0, fault}, {31'd0, m_fault});
    if (m_valid) begin
      check("out_pc", out_pc, m_opc);
      check("out_inst", out_inst, m_inst);
    end
  endtask

  initial begin
    logic [31:0] last;
    bit done;
    step(0, 0, 0, 1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, INST_NOP);
    step(0, 0, 0, 1);
    check("rst_pc", fetch_addr, 32'd16);
    step(1, 0, 0, 1);
    check("first_pc", out_pc, 32'd16);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    step(1, 0, 0, 1);
    check("second_pc", out_pc, 32'd20);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("stall_pc", out_pc, 32'd20);
      check("stall_inst", out_inst, mem_word(32'd20));
      check("stall_fetch", fetch_addr, 32'd24);
    end
    step(1, 0, 0, 1);
    check("release_pc", out_pc, 32'd24);
    step(1, 0, 0, 0);
    step(1, 1, 32'd16, 0);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 0);
    check("redir_pc", out_pc, 32'd16);
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    step(1, 1, 32'd18, 1);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    step(1, 1, 32'd32, 1);
    step(1, 0, 0, 0);
    step(1, 1, 32'd40, 0);
    check("halt_fault", {31'd0, fault}, 32'd1);
    check("halt_pc", fetch_addr, 32'd20);
    step(0, 1, 32'd40, 1);
    check("halt_rst_pc", fetch_addr, 32'd16);
    check("halt_rst_fault", {31'd0, fault}, 32'd0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("stall_rst_pc", fetch_addr, 32'd16);
    check("stall_rst_valid", {31'd0, out_valid}, 32'd0);
    last = 32'hFFFF_FFFF;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1, 0, 0, 1);
      if (out_valid) last = out_pc;
      if (fault) done = 1;
    end
    check("overrun_faulted", {31'd0, done}, 32'd1);
    check("overrun_last", last, MEM_SIZE);
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, rdy;
      logic [31:0] rpc;
      r = ($urandom_range(0, 59) != 0);
      rv = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 300) : $urandom_range(0, MEM_SIZE / 4) * 4;
      step(r, rv, rpc, rdy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
